i2c_slave_responder: RTL and testbench

- Synthesizable I2C target (slave) sitting directly downstream of the I2CMB master on the shared SCL/SDA bus.
- Decodes START, STOP, address and R/W; ACKs its own address; streams written bytes out; serves read bytes from a local byte source.
- Used as the hardware counterpart of the i2c agent for closed-loop and emulation runs against the same i2c_op_t WRITE/READ semantics.

---
 rtl/i2c_slave_responder_if.sv | 31 +++
 rtl/i2c_slave_responder.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_responder_if.sv
// Bus bundle between the I2C target and its environment: wired SCL/SDA levels,
// open-drain enables, the received-byte stream and the read-byte source.
interface i2c_slave_responder_if #(
  parameter int unsigned DW = 8
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          scl_oe;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          start_det;
  logic          stop_det;
  logic          busy;
  logic          rd_underrun;

  modport slave (
    input  scl_i, sda_i, rd_data, rd_valid,
    output sda_oe, scl_oe, wr_data, wr_valid, rd_ready,
           start_det, stop_det, busy, rd_underrun
  );

  modport master (
    output scl_i, sda_i, rd_data, rd_valid,
    input  sda_oe, scl_oe, wr_data, wr_valid, rd_ready,
           start_det, stop_det, busy, rd_underrun
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: decodes START/STOP/address, ACKs its own address, streams write bytes
// out and serves read bytes. Define I2C_CLK_STRETCH_EN to stretch SCL on read underrun.
module i2c_slave_responder #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter int unsigned HOLD_CYCLES    = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  i2c_slave_responder_if.slave bus
);

  localparam int unsigned DW     = I2C_DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(DW);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DW - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              ack_ph_q, ack_ph_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              sda_oe_q, sda_oe_d;
  logic              scl_oe_q, scl_oe_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              rd_ready_q, rd_ready_d;
  logic              start_det_q, start_det_d;
  logic              stop_det_q, stop_det_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;
`ifdef I2C_CLK_STRETCH_EN
  logic              stretch_q, stretch_d;
  logic              rel_pend_q, rel_pend_d;
`endif

  logic scl_rise_c, scl_fall_c, start_c, stop_c, drive_pt_c, addr_hit_c, load_req_c;

  // Bus events from the synchronized levels and the edge-detect register.
  assign scl_rise_c = scl_s2_q & ~scl_d_q;
  assign scl_fall_c = ~scl_s2_q & scl_d_q;
  assign start_c    = scl_s2_q & scl_d_q & ~sda_s2_q & sda_d_q;
  assign stop_c     = scl_s2_q & scl_d_q & sda_s2_q & ~sda_d_q;
  assign drive_pt_c = (hold_cnt_q == HOLD_ONE);
  assign addr_hit_c = (shift_q[6:0] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_ph_d    = ack_ph_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    rd_ready_d  = 1'b0;
    start_det_d = start_c;
    stop_det_d  = stop_c;
    busy_d      = busy_q;
    underrun_d  = underrun_q;
    load_req_c  = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    stretch_d   = stretch_q;
    rel_pend_d  = rel_pend_q;
`endif
    // SDA may only change HOLD_CYCLES after a detected SCL fall.
    if (scl_fall_c) begin
      hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_ONE;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    case (state_q)
      S_ADDR: begin
        if (scl_rise_c) begin
          shift_d   = {shift_q[DW-2:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            rw_d     = sda_s2_q;
            ack_ph_d = 1'b0;
            state_d  = addr_hit_c ? S_ADDR_ACK : S_IGNORE;
          end
        end
      end
      S_ADDR_ACK: begin
        if (drive_pt_c) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            ack_ph_d = 1'b0;
            if (rw_q) begin
              load_req_c = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_WR_DATA;
            end
          end
        end
      end
      S_WR_DATA: begin
        if (scl_rise_c) begin
          shift_d   = {shift_q[DW-2:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            wr_data_d  = {shift_q[DW-2:0], sda_s2_q};
            wr_valid_d = 1'b1;
            ack_ph_d   = 1'b0;
            state_d    = S_WR_ACK;
          end
        end
      end
      S_WR_ACK: begin
        if (drive_pt_c) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_WR_DATA;
          end
        end
      end
      S_RD_DATA: begin
`ifdef I2C_CLK_STRETCH_EN
        // SCL is held low here until the byte source catches up.
        if (stretch_q) begin
          if (bus.rd_valid) begin
            shift_d    = bus.rd_data;
            sda_oe_d   = ~bus.rd_data[DW-1];
            rd_ready_d = 1'b1;
            stretch_d  = 1'b0;
            rel_pend_d = 1'b1;
            hold_cnt_d = HOLD_LOAD;
          end
        end else
`endif
        begin
          if (drive_pt_c) begin
            sda_oe_d = ~shift_q[DW-1];
          end
          if (scl_rise_c) begin
            shift_d   = {shift_q[DW-2:0], 1'b1};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              ack_ph_d = 1'b0;
              state_d  = S_RD_ACK;
            end
          end
        end
      end
      S_RD_ACK: begin
        if (drive_pt_c && !ack_ph_q) begin
          sda_oe_d = 1'b0;
        end
        if (scl_rise_c) begin
          if (sda_s2_q) begin
            state_d = S_IGNORE;
          end else begin
            ack_ph_d = 1'b1;
          end
        end
        if (drive_pt_c && ack_ph_q) begin
          ack_ph_d   = 1'b0;
          load_req_c = 1'b1;
        end
      end
      S_IGNORE: sda_oe_d = 1'b0;
      default: ;
    endcase

    // Read load point: first bit goes out with the load.
    if (load_req_c) begin
      bit_cnt_d = '0;
      state_d   = S_RD_DATA;
      if (bus.rd_valid) begin
        shift_d    = bus.rd_data;
        sda_oe_d   = ~bus.rd_data[DW-1];
        rd_ready_d = 1'b1;
      end else begin
`ifdef I2C_CLK_STRETCH_EN
        sda_oe_d  = 1'b0;
        scl_oe_d  = 1'b1;
        stretch_d = 1'b1;
`else
        shift_d    = '1;
        sda_oe_d   = 1'b0;
        underrun_d = 1'b1;
`endif
      end
    end

`ifdef I2C_CLK_STRETCH_EN
    if (rel_pend_q && drive_pt_c) begin
      scl_oe_d   = 1'b0;
      rel_pend_d = 1'b0;
    end
`endif

    // START/STOP win over whatever the byte engine was doing.
    if (stop_c || start_c) begin
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      hold_cnt_d = '0;
      ack_ph_d   = 1'b0;
      bit_cnt_d  = '0;
      wr_valid_d = 1'b0;
      rd_ready_d = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      stretch_d  = 1'b0;
      rel_pend_d = 1'b0;
`endif
    end
    if (stop_c) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end
    if (start_c) begin
      state_d    = S_ADDR;
      busy_d     = 1'b1;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_d_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_d_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_ph_q    <= 1'b0;
      hold_cnt_q  <= '0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_ready_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      stretch_q   <= 1'b0;
      rel_pend_q  <= 1'b0;
`endif
    end else begin
      scl_s1_q    <= bus.scl_i;
      scl_s2_q    <= scl_s1_q;
      scl_d_q     <= scl_s2_q;
      sda_s1_q    <= bus.sda_i;
      sda_s2_q    <= sda_s1_q;
      sda_d_q     <= sda_s2_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_ph_q    <= ack_ph_d;
      hold_cnt_q  <= hold_cnt_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      rd_ready_q  <= rd_ready_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
`ifdef I2C_CLK_STRETCH_EN
      stretch_q   <= stretch_d;
      rel_pend_q  <= rel_pend_d;
`endif
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.scl_oe      = scl_oe_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.rd_ready    = rd_ready_q;
  assign bus.start_det   = start_det_q;
  assign bus.stop_det    = stop_det_q;
  assign bus.busy        = busy_q;
  assign bus.rd_underrun = underrun_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-level I2C master on a wired-AND bus, byte source,
// pulse monitor and a transaction-level reference of what the target should do.
module tb_i2c_slave_responder;
  localparam int unsigned Q = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_responder_if bus();

  i2c_slave_responder #(
    .SLAVE_ADDR(7'h22), .I2C_DATA_WIDTH(8), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic m_scl_oe = 1'b0;
  logic m_sda_oe = 1'b0;
  assign bus.scl_i = ~(m_scl_oe | bus.scl_oe);
  assign bus.sda_i = ~(m_sda_oe | bus.sda_oe);

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wr_got[$];
  logic [7:0] rd_src[$];
  int n_start, n_stop, n_rdy;
  bit sda_seen, scl_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: only the configured 7-bit address is claimed; general call never is.
  function automatic bit ref_acks(input logic [6:0] a);
    return a == 7'h22;
  endfunction

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_got.size()) ? 32'(wr_got[i]) : 32'hDEAD;
  endfunction

  // Byte source: pops on rd_ready, presents the queue head.
  always @(negedge clk) begin
    if (bus.rd_ready && rd_src.size() != 0) void'(rd_src.pop_front());
    bus.rd_valid = (rd_src.size() != 0);
    bus.rd_data  = (rd_src.size() != 0) ? rd_src[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_valid)  wr_got.push_back(bus.wr_data);
      if (bus.start_det) n_start++;
      if (bus.stop_det)  n_stop++;
      if (bus.rd_ready)  n_rdy++;
      if (bus.sda_oe)    sda_seen = 1'b1;
      if (bus.scl_oe)    scl_seen = 1'b1;
    end
  end

  task automatic clr_mon();
    wr_got.delete();
    n_start = 0; n_stop = 0; n_rdy = 0;
    sda_seen = 1'b0; scl_seen = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_release();
    m_scl_oe = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.scl_i) break;
      wait_clk(1);
    end
    if (!bus.scl_i) check("scl_release_timeout", 32'(bus.scl_i), 32'h1);
  endtask

  task automatic clk_bit(input bit out_bit, output bit in_bit);
    m_sda_oe = ~out_bit;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    in_bit = bus.sda_i;
    wait_clk(Q);
    m_scl_oe = 1'b1;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    m_sda_oe = 1'b1;
    wait_clk(Q);
    m_scl_oe = 1'b1;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    m_sda_oe = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    bit d;
    for (int i = 7; i > 7 - n; i--) clk_bit(b[i], d);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit s;
    send_bits(b, 8);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit nack);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic rand_txn(input int idx);
    logic [6:0] a;
    logic [7:0] b;
    logic [7:0] data[$];
    logic [7:0] exp_rd[$];
    bit rd, ack, hit;
    int n;
    a = 7'h22;
    if ($urandom_range(0, 3) == 0) begin
      a = 7'($urandom_range(0, 127));
      if (a == 7'h22) a = 7'h00;
    end
    rd  = 1'($urandom_range(0, 1));
    n   = $urandom_range(1, 3);
    hit = ref_acks(a);
    clr_mon();
    rd_src.delete();
    if (rd) for (int i = 0; i < n; i++) rd_src.push_back(8'($urandom_range(0, 255)));
    exp_rd = rd_src;
    wait_clk(2);
    i2c_start();
    send_byte({a, rd}, ack);
    check($sformatf("rnd%0d_addr_ack", idx), 32'(ack), 32'(hit));
    if (hit && !rd) begin
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        data.push_back(b);
        send_byte(b, ack);
        check($sformatf("rnd%0d_data_ack", idx), 32'(ack), 32'h1);
      end
    end else if (hit) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(b, i == n - 1);
        check($sformatf("rnd%0d_rd_byte", idx), 32'(b), 32'(exp_rd[i]));
      end
    end
    i2c_stop();
    check($sformatf("rnd%0d_wr_cnt", idx), 32'(wr_got.size()), 32'(data.size()));
    for (int i = 0; i < data.size(); i++)
      check($sformatf("rnd%0d_wr_byte", idx), wr_at(i), 32'(data[i]));
    check($sformatf("rnd%0d_rdy_cnt", idx), 32'(n_rdy), (hit && rd) ? 32'(n) : 32'h0);
    if (!hit) check($sformatf("rnd%0d_no_sda", idx), 32'(sda_seen), 32'h0);
    check($sformatf("rnd%0d_start_stop", idx), 32'({n_start[7:0], n_stop[7:0]}), 32'h0101);
    check($sformatf("rnd%0d_busy", idx), 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ack;
    int k;
    logic [7:0] b;

    clr_mon();
    wait_clk(5);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'h0);
    check("rst_scl_oe", 32'(bus.scl_oe), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_pulses", 32'({bus.wr_valid, bus.rd_ready, bus.start_det, bus.stop_det, bus.rd_underrun}), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // Directed write with START-to-busy latency.
    clr_mon();
    m_sda_oe = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      wait_clk(1);
      if (bus.busy) begin k = i; break; end
    end
    check("busy_latency", 32'(k), 32'h3);
    wait_clk(Q);
    m_scl_oe = 1'b1;
    wait_clk(Q);
    send_byte(8'h44, ack);
    check("wr_addr_ack", 32'(ack), 32'h1);
    send_byte(8'hA5, ack);
    check("wr_d0_ack", 32'(ack), 32'h1);
    send_byte(8'h3C, ack);
    check("wr_d1_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("wr_cnt", 32'(wr_got.size()), 32'h2);
    check("wr_b0", wr_at(0), 32'hA5);
    check("wr_b1", wr_at(1), 32'h3C);
    check("wr_stop_det", 32'(n_stop), 32'h1);
    check("wr_busy_end", 32'(bus.busy), 32'h0);

    // Address mismatch.
    clr_mon();
    i2c_start();
    send_byte(8'h46, ack);
    check("mis_nack", 32'(ack), 32'h0);
    i2c_stop();
    check("mis_sda_never", 32'(sda_seen), 32'h0);
    check("mis_no_wr", 32'(wr_got.size()), 32'h0);
    check("mis_busy", 32'(bus.busy), 32'h0);

    // Read two bytes, ACK then NACK.
    clr_mon();
    rd_src.delete();
    rd_src.push_back(8'h5A);
    rd_src.push_back(8'hC3);
    wait_clk(2);
    i2c_start();
    send_byte(8'h45, ack);
    check("rd_addr_ack", 32'(ack), 32'h1);
    recv_byte(b, 1'b0);
    check("rd_b0", 32'(b), 32'h5A);
    recv_byte(b, 1'b1);
    check("rd_b1", 32'(b), 32'hC3);
    check("rd_sda_released", 32'(bus.sda_oe), 32'h0);
    i2c_stop();
    check("rd_rdy_cnt", 32'(n_rdy), 32'h2);
    check("rd_underrun_clear", 32'(bus.rd_underrun), 32'h0);

    // Write, repeated START, read with an empty byte source.
    clr_mon();
    rd_src.delete();
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h11, ack);
    check("rs_wr_ack", 32'(ack), 32'h1);
    i2c_start();
    send_byte(8'h45, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'h1);
`ifdef I2C_CLK_STRETCH_EN
    fork
      begin
        wait_clk(200);
        rd_src.push_back(8'h77);
      end
    join_none
    recv_byte(b, 1'b1);
    check("rs_rd_byte", 32'(b), 32'h77);
    check("rs_underrun", 32'(bus.rd_underrun), 32'h0);
    check("rs_stretched", 32'(scl_seen), 32'h1);
    check("rs_rdy_cnt", 32'(n_rdy), 32'h1);
`else
    recv_byte(b, 1'b1);
    check("rs_rd_byte", 32'(b), 32'hFF);
    check("rs_underrun", 32'(bus.rd_underrun), 32'h1);
    check("rs_rdy_cnt", 32'(n_rdy), 32'h0);
`endif
    i2c_stop();
    check("rs_start_cnt", 32'(n_start), 32'h2);
    check("rs_wr_byte", wr_at(0), 32'h11);

    // Abort mid-byte, then a clean write.
    clr_mon();
    i2c_start();
    send_byte(8'h44, ack);
    send_bits(8'hE7, 3);
    i2c_stop();
    check("ab_no_wr", 32'(wr_got.size()), 32'h0);
    check("ab_sda_oe", 32'(bus.sda_oe), 32'h0);
    check("ab_busy", 32'(bus.busy), 32'h0);
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h99, ack);
    check("ab_d_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("ab_wr_cnt", 32'(wr_got.size()), 32'h1);
    check("ab_wr_byte", wr_at(0), 32'h99);

    for (int t = 0; t < 8; t++) rand_txn(t);

    // Reset while the target is driving a read bit low.
    clr_mon();
    rd_src.delete();
    rd_src.push_back(8'h00);
    wait_clk(2);
    i2c_start();
    send_byte(8'h45, ack);
    check("ar_driving", 32'(bus.sda_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_sda_oe", 32'(bus.sda_oe), 32'h0);
    check("ar_busy", 32'(bus.busy), 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    m_scl_oe = 1'b0;
    wait_clk(2 * Q);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
